// File: rtl/ack_retransmit_ctrl_pkg.sv
// Shared types and default parameters for the alternating-bit ACK/retransmit
// controller.
//   ack_ctrl_state_t        : controller FSM state encoding
//   *_DEF localparams       : default timeout, retry limit and ACK counter width
package ack_retransmit_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_DONE = 3'd2,
    WAIT_ACK  = 3'd3,
    FAIL      = 3'd4
  } ack_ctrl_state_t;

  localparam int unsigned ACK_TIMEOUT_CYCLES_DEF = 1000;
  localparam int unsigned MAX_RETRIES_DEF        = 8;
  localparam int unsigned CNT_WIDTH_DEF          = 4;

endpackage

// File: rtl/ack_retransmit_ctrl_counter.sv
// Generic loadable up/down counter, used here as the ACK timeout timer.
// Ports:
//   clk, rst_l : clock, synchronous active-low reset (q_o -> 0)
//   load_i     : load d_i (takes priority over en_i)
//   en_i       : count enable
//   up_i       : 1 = increment, 0 = decrement
//   d_i        : load value
//   q_o        : current count
module ack_retransmit_ctrl_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         load_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end else if (en_i) begin
      q_o <= up_i ? q_o + W'(1) : q_o - W'(1);
    end
  end

endmodule

// File: rtl/ack_retransmit_ctrl.sv
// Sender-side stop-and-wait (alternating-bit) controller. Launches a packet
// through the Sender, waits for a Receiver ACK carrying the matching sequence
// bit, retransmits on timeout and declares link failure after MAX_RETRIES
// consecutive timeouts on one packet.
// Ports:
//   clk, rst_l        : clock, synchronous active-low reset
//   link_en           : low aborts any transfer (except FAIL) back to IDLE
//   update_data       : level request to send the current game state
//   send_done         : Sender finished shifting the packet out (pulse)
//   ack_received      : Receiver decoded an ACK (pulse), ack_seqNum its bit
//   clear_fail        : leave FAIL back to IDLE
//   send_start        : one-cycle launch pulse to the Sender
//   sender_seqNum     : sequence bit embedded in the packet
//   busy / link_fail  : status flags
//   retry_cnt         : timeouts seen on the current packet
//   acks_received_cnt : matching ACKs accepted (wraps)
//   dbg_state         : current FSM state for observation
// Handshakes: there is no back-pressure anywhere. send_start, send_done and
// ack_received are single-cycle strobes that are acted on in the cycle they
// are high and only in the state that expects them; elsewhere they are dropped.
module ack_retransmit_ctrl
  import ack_retransmit_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT_CYCLES = ACK_TIMEOUT_CYCLES_DEF,
  parameter int MAX_RETRIES        = MAX_RETRIES_DEF,
  parameter int CNT_WIDTH          = CNT_WIDTH_DEF,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 link_en,
  input  logic                 update_data,
  input  logic                 send_done,
  input  logic                 ack_received,
  input  logic                 ack_seqNum,
  input  logic                 clear_fail,
  output logic                 send_start,
  output logic                 sender_seqNum,
  output logic                 busy,
  output logic                 link_fail,
  output logic [RW-1:0]        retry_cnt,
  output logic [CNT_WIDTH-1:0] acks_received_cnt,
  output ack_ctrl_state_t      dbg_state
);

  localparam int TW = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;

  ack_ctrl_state_t      state_q;
  logic                 seq_q;
  logic                 pending_q;
  logic                 send_start_q;
  logic                 busy_q;
  logic                 link_fail_q;
  logic [RW-1:0]        retry_q;
  logic [CNT_WIDTH-1:0] acks_q;
  logic [TW-1:0]        timer_q;

  logic          ack_valid;
  logic          timeout;
  logic [RW-1:0] retry_inc;
  logic          timer_load;
  logic          timer_en;

  assign ack_valid = ack_received && (ack_seqNum == seq_q);
  assign timeout   = (timer_q == TW'(ACK_TIMEOUT_CYCLES - 1));
  assign retry_inc = retry_q + RW'(1);

  // The timer is held at zero whenever we are not waiting for an ACK, so it
  // always starts from 0 on entry to WAIT_ACK and is cleared by an abort.
  assign timer_load = (state_q != WAIT_ACK) || !link_en;
  assign timer_en   = (state_q == WAIT_ACK);

  ack_retransmit_ctrl_counter #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_l  (rst_l),
    .load_i (timer_load),
    .en_i   (timer_en),
    .up_i   (1'b1),
    .d_i    ('0),
    .q_o    (timer_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      seq_q        <= 1'b0;
      pending_q    <= 1'b0;
      send_start_q <= 1'b0;
      busy_q       <= 1'b0;
      link_fail_q  <= 1'b0;
      retry_q      <= '0;
      acks_q       <= '0;
    end else begin
      send_start_q <= 1'b0;

      // Requests during a transfer coalesce into a single pending flag.
      if (update_data && (state_q inside {LAUNCH, WAIT_DONE, WAIT_ACK})) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (link_en && (update_data || pending_q)) begin
            state_q      <= LAUNCH;
            send_start_q <= 1'b1;
            busy_q       <= 1'b1;
            pending_q    <= 1'b0;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (send_done) begin
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A valid ACK beats a timeout landing in the same cycle.
          if (ack_valid) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            seq_q   <= ~seq_q;
            acks_q  <= acks_q + CNT_WIDTH'(1);
            retry_q <= '0;
          end else if (timeout) begin
            retry_q <= retry_inc;
            if (retry_inc == RW'(MAX_RETRIES)) begin
              state_q     <= FAIL;
              link_fail_q <= 1'b1;
              pending_q   <= 1'b0;
            end else begin
              state_q      <= LAUNCH;
              send_start_q <= 1'b1;
            end
          end
        end
        FAIL: begin
          if (clear_fail) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            link_fail_q <= 1'b0;
            retry_q     <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Abort overrides everything outside FAIL; sequence bit and ACK count
      // survive so the peer stays in step.
      if (!link_en && (state_q != FAIL)) begin
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        send_start_q <= 1'b0;
        pending_q    <= 1'b0;
        retry_q      <= '0;
      end
    end
  end

  assign send_start        = send_start_q;
  assign sender_seqNum     = seq_q;
  assign busy              = busy_q;
  assign link_fail         = link_fail_q;
  assign retry_cnt         = retry_q;
  assign acks_received_cnt = acks_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_ack_retransmit_ctrl.sv
module tb_ack_retransmit_ctrl;
  import ack_retransmit_ctrl_pkg::*;

  localparam int T  = 16;
  localparam int MR = 3;
  localparam int CW = 4;

  logic            clk;
  logic            rst_l;
  logic            link_en;
  logic            update_data;
  logic            send_done;
  logic            ack_received;
  logic            ack_seqNum;
  logic            clear_fail;
  logic            send_start;
  logic            sender_seqNum;
  logic            busy;
  logic            link_fail;
  logic [1:0]      retry_cnt;
  logic [CW-1:0]   acks_received_cnt;
  ack_ctrl_state_t dbg_state;

  int checks   = 0;
  int failures = 0;
  logic          exp_seq;
  logic [CW-1:0] exp_acks;

  ack_retransmit_ctrl #(
    .ACK_TIMEOUT_CYCLES (T),
    .MAX_RETRIES        (MR),
    .CNT_WIDTH          (CW)
  ) dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .link_en           (link_en),
    .update_data       (update_data),
    .send_done         (send_done),
    .ack_received      (ack_received),
    .ack_seqNum        (ack_seqNum),
    .clear_fail        (clear_fail),
    .send_start        (send_start),
    .sender_seqNum     (sender_seqNum),
    .busy              (busy),
    .link_fail         (link_fail),
    .retry_cnt         (retry_cnt),
    .acks_received_cnt (acks_received_cnt),
    .dbg_state         (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input ack_ctrl_state_t exp);
    check(tag, 32'(dbg_state), 32'(exp));
  endtask

  // request from IDLE, confirm launch, complete the send -> WAIT_ACK (timer 0)
  task automatic start_xfer(input string tag);
    update_data = 1'b1;
    tick(1);
    update_data = 1'b0;
    check({tag, "_launch"}, 32'(send_start), 32'd1);
    check({tag, "_seq"}, 32'(sender_seqNum), 32'(exp_seq));
    tick(1);
    send_done = 1'b1;
    tick(1);
    send_done = 1'b0;
  endtask

  // from LAUNCH: go to WAIT_DONE then complete the send -> WAIT_ACK
  task automatic finish_send();
    tick(1);
    send_done = 1'b1;
    tick(1);
    send_done = 1'b0;
  endtask

  task automatic send_ack(input logic s);
    ack_received = 1'b1;
    ack_seqNum   = s;
    tick(1);
    ack_received = 1'b0;
    ack_seqNum   = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; link_en = 1'b0; update_data = 1'b0; send_done = 1'b0;
    ack_received = 1'b0; ack_seqNum = 1'b0; clear_fail = 1'b0;
    exp_seq = 1'b0; exp_acks = '0;
    tick(2);

    // reset state
    check("rst_send_start", 32'(send_start), 32'd0);
    check("rst_seq", 32'(sender_seqNum), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_link_fail", 32'(link_fail), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_acks", 32'(acks_received_cnt), 32'd0);
    check_state("rst_state", IDLE);
    rst_l = 1'b1;
    link_en = 1'b1;
    tick(1);

    // 1. nominal transfer
    update_data = 1'b1;
    tick(1);
    update_data = 1'b0;
    check("t1_send_start", 32'(send_start), 32'd1);
    check("t1_seq", 32'(sender_seqNum), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick(1);
    check("t1_start_one_cycle", 32'(send_start), 32'd0);
    check_state("t1_wait_done", WAIT_DONE);
    send_done = 1'b1;
    tick(1);
    send_done = 1'b0;
    check_state("t1_wait_ack", WAIT_ACK);
    tick(4);
    send_ack(1'b0);
    exp_seq = 1'b1; exp_acks = 4'd1;
    check("t1_seq_toggled", 32'(sender_seqNum), 32'd1);
    check("t1_acks", 32'(acks_received_cnt), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);

    // 2. single timeout then retransmit with same seq
    start_xfer("t2");
    tick(T - 1);
    check_state("t2_still_waiting", WAIT_ACK);
    check("t2_no_retry_yet", 32'(retry_cnt), 32'd0);
    tick(1);
    check("t2_retry1", 32'(retry_cnt), 32'd1);
    check("t2_resend", 32'(send_start), 32'd1);
    check("t2_same_seq", 32'(sender_seqNum), 32'd1);
    finish_send();
    send_ack(1'b1);
    exp_seq = 1'b0; exp_acks = 4'd2;
    check("t2_retry_cleared", 32'(retry_cnt), 32'd0);
    check("t2_seq", 32'(sender_seqNum), 32'(exp_seq));
    check("t2_acks", 32'(acks_received_cnt), 32'(exp_acks));

    // 3. three timeouts -> FAIL
    start_xfer("t3");
    tick(T);
    check("t3_retry1", 32'(retry_cnt), 32'd1);
    finish_send();
    tick(T);
    check("t3_retry2", 32'(retry_cnt), 32'd2);
    check("t3_resend2", 32'(send_start), 32'd1);
    finish_send();
    tick(T);
    check("t3_link_fail", 32'(link_fail), 32'd1);
    check("t3_retry3", 32'(retry_cnt), 32'd3);
    check("t3_no_send", 32'(send_start), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    check_state("t3_state", FAIL);
    update_data = 1'b1;
    tick(1);
    update_data = 1'b0;
    check("t3_req_ignored", 32'(send_start), 32'd0);
    tick(2);
    check_state("t3_still_fail", FAIL);
    clear_fail = 1'b1;
    tick(1);
    clear_fail = 1'b0;
    check_state("t3_cleared", IDLE);
    check("t3_link_fail_low", 32'(link_fail), 32'd0);
    check("t3_retry_zero", 32'(retry_cnt), 32'd0);
    check("t3_seq_kept", 32'(sender_seqNum), 32'd0);
    tick(1);
    check("t3_not_latched", 32'(send_start), 32'd0);

    // 4. stale ACK ignored; ACK on the timeout cycle wins
    start_xfer("t4a");
    send_ack(1'b0);
    exp_seq = 1'b1; exp_acks = 4'd3;
    start_xfer("t4");
    tick(3);
    send_ack(1'b0);
    check_state("t4_stale_ignored", WAIT_ACK);
    check("t4_seq_held", 32'(sender_seqNum), 32'd1);
    check("t4_acks_held", 32'(acks_received_cnt), 32'd3);
    tick(T - 5);
    check_state("t4_before_timeout", WAIT_ACK);
    tick(1);
    check("t4_timeout_fired", 32'(retry_cnt), 32'd1);
    check("t4_resend", 32'(send_start), 32'd1);
    finish_send();
    tick(T - 1);
    send_ack(1'b1);
    exp_seq = 1'b0; exp_acks = 4'd4;
    check_state("t4_ack_wins", IDLE);
    check("t4_no_retry", 32'(retry_cnt), 32'd0);
    check("t4_no_resend", 32'(send_start), 32'd0);
    check("t4_acks", 32'(acks_received_cnt), 32'(exp_acks));

    // 5. coalesced requests and counter wrap
    update_data = 1'b1;
    tick(1);
    update_data = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      update_data = 1'b1;
      tick(1);
      update_data = 1'b0;
      tick(1);
    end
    send_done = 1'b1;
    tick(1);
    send_done = 1'b0;
    send_ack(1'b0);
    exp_seq = 1'b1; exp_acks = 4'd5;
    tick(1);
    check("t5_extra_send", 32'(send_start), 32'd1);
    check("t5_extra_seq", 32'(sender_seqNum), 32'd1);
    finish_send();
    send_ack(1'b1);
    exp_seq = 1'b0; exp_acks = 4'd6;
    tick(1);
    check("t5_only_one_extra", 32'(send_start), 32'd0);
    check_state("t5_idle", IDLE);
    for (int i = 0; i < 10; i++) begin
      start_xfer("t5w");
      send_ack(exp_seq);
      exp_seq  = ~exp_seq;
      exp_acks = exp_acks + 4'd1;
      if (i == 8) check("t5_acks15", 32'(acks_received_cnt), 32'd15);
    end
    check("t5_wrap", 32'(acks_received_cnt), 32'd0);
    check("t5_seq_after_wrap", 32'(sender_seqNum), 32'(exp_seq));

    // 6. abort via link_en, then reset mid-transfer
    start_xfer("t6");
    tick(T);
    check("t6_retry1", 32'(retry_cnt), 32'd1);
    finish_send();
    update_data = 1'b1;
    tick(1);
    update_data = 1'b0;
    link_en = 1'b0;
    tick(1);
    check_state("t6_abort_idle", IDLE);
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_retry", 32'(retry_cnt), 32'd0);
    check("t6_abort_seq", 32'(sender_seqNum), 32'(exp_seq));
    check("t6_abort_acks", 32'(acks_received_cnt), 32'(exp_acks));
    link_en = 1'b1;
    tick(1);
    check("t6_pending_cleared", 32'(send_start), 32'd0);
    check_state("t6_stay_idle", IDLE);
    start_xfer("t6b");
    send_ack(exp_seq);
    exp_seq = ~exp_seq; exp_acks = exp_acks + 4'd1;
    check("t6_seq_before_rst", 32'(sender_seqNum), 32'd1);
    start_xfer("t6c");
    tick(T);
    rst_l = 1'b0;
    tick(1);
    check("t6_rst_send_start", 32'(send_start), 32'd0);
    check("t6_rst_seq", 32'(sender_seqNum), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_link_fail", 32'(link_fail), 32'd0);
    check("t6_rst_retry", 32'(retry_cnt), 32'd0);
    check("t6_rst_acks", 32'(acks_received_cnt), 32'd0);
    check_state("t6_rst_state", IDLE);
    rst_l = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
